// File: rtl/mem_lsu_master.sv
// ---------------------------------------------------------------------------
// mem_lsu_master
//
// This is a load/store unit that sits between a RISC-V core and a simple
// word-addressed memory. The memory read path is combinational.
//
// It handles one request at a time:
//   - Loads take one memory read cycle. The selected lane is then sign- or
//     zero-extended.
//   - Word stores write directly.
//   - Byte and half stores use a read-modify-write sequence.
//   - Misaligned accesses, illegal width codes and out-of-range addresses
//     go straight to an error response. No memory access is made for them.
//
// Ports
//   clk, rst                 : clock; asynchronous active-high reset
//   req_valid / req_ready    : request handshake from the core
//   req_store                : 1 = store, 0 = load
//   req_funct3               : RISC-V width code (B/H/W/BU/HU)
//   req_addr, req_wdata      : byte address and right-aligned store data
//   resp_valid / resp_ready  : response handshake back to the core
//   resp_rdata, resp_err     : extended load data and error flag
//   mem_a, mem_we, mem_wd    : word address, write enable, write data
//   mem_rd                   : read word (combinational from mem_a)
// ---------------------------------------------------------------------------
module mem_lsu_master #(
    parameter int MEM_AW  = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    // TIMEOUT is a reserved parameter. Any non-zero value is rejected
    // when the design is elaborated.
    generate
        if (TIMEOUT != 0) begin : g_timeout_reserved
            $error("mem_lsu_master: TIMEOUT is reserved and must be 0");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t              state, state_nx;
    logic                lat_store;
    logic [2:0]          lat_f3;
    logic [MEM_AW+1:0]   lat_addr;
    logic [31:0]         lat_wdata;
    logic [31:0]         rword;
    logic [31:0]         rdata_q;
    logic                err_q;

    logic                accept;
    logic                misaligned, illegal, out_of_range, req_bad;
    logic [31:0]         byte_sh;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [31:0]         load_data;
    logic [31:0]         merged;

    assign accept = req_valid && (state == IDLE);

    // Request checks are made on the live request inputs, because they
    // only matter on the edge where the request is accepted.
    // Width code 110 also matches the W pattern in its low bits. That
    // case is harmless, since 110 is flagged as illegal anyway.
    always_comb begin
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        illegal      = req_store ? (req_funct3 > 3'b010)
                                 : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                                    (req_funct3 == 3'b111));
        out_of_range = (req_addr >> (MEM_AW + 2)) != 32'd0;
        req_bad      = misaligned || illegal || out_of_range;
    end

    // This block picks the addressed lane out of the word being read and
    // extends it according to the latched width code.
    always_comb begin
        byte_sh   = mem_rd >> {lat_addr[1:0], 3'b000};
        lane_b    = byte_sh[7:0];
        lane_h    = lat_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        load_data = mem_rd;
        case (lat_f3)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {24'd0, lane_b};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = mem_rd;
        endcase
    end

    // This block builds the read-modify-write word: the captured word,
    // with only the addressed byte or half replaced by the store data.
    always_comb begin
        merged = rword;
        if (lat_f3[1:0] == 2'b00) begin
            case (lat_addr[1:0])
                2'b00:   merged[7:0]   = lat_wdata[7:0];
                2'b01:   merged[15:8]  = lat_wdata[7:0];
                2'b10:   merged[23:16] = lat_wdata[7:0];
                default: merged[31:24] = lat_wdata[7:0];
            endcase
        end else if (lat_f3[1:0] == 2'b01) begin
            if (lat_addr[1]) merged[31:16] = lat_wdata[15:0];
            else             merged[15:0]  = lat_wdata[15:0];
        end
    end

    // Next-state logic. Byte and half stores pass through RD so that the
    // existing word is captured before it is written back.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)                      state_nx = RESP;
                    else if (!req_store)              state_nx = RD;
                    else if (req_funct3 == 3'b010)    state_nx = WR;
                    else                              state_nx = RD;
                end
            end
            RD:      state_nx = lat_store ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // State register, request latches and response registers.
    // The response registers are loaded on the way into RESP and are
    // cleared once the response is consumed. Outside RESP they read as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_store <= 1'b0;
            lat_f3    <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            rword     <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_store <= req_store;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr[MEM_AW+1:0];
                lat_wdata <= req_wdata;
                rdata_q   <= 32'd0;
                err_q     <= req_bad;
            end
            if (state == RD) begin
                rword <= mem_rd;
                if (!lat_store) rdata_q <= load_data;
            end
            if ((state == RESP) && resp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = (state == WR);
    assign mem_a      = ((state == RD) || (state == WR)) ? lat_addr[MEM_AW+1:2] : '0;
    assign mem_wd     = (state == WR) ? ((lat_f3 == 3'b010) ? lat_wdata : merged) : 32'd0;

endmodule

// File: tb/tb_mem_lsu_master.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu_master
//
// Directed testbench for mem_lsu_master.
//
// A small word memory is modelled here. Its read port is combinational
// and its write port is synchronous. Expected values are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_mem_lsu_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];
    int          weCount = 0;
    logic [15:0] lastA   = '0;
    logic [31:0] lastWd  = '0;
    logic        loadEn  = 1'b0;
    logic [5:0]  loadIdx = '0;
    logic [31:0] loadVal = '0;

    int checks = 0;
    int errors = 0;

    mem_lsu_master #(.MEM_AW(16), .TIMEOUT(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[5:0]];

    // The memory model has a single writer. The DUT write takes priority
    // over a bench preload.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[5:0]] <= mem_wd;
            weCount         <= weCount + 1;
            lastA           <= mem_a;
            lastWd          <= mem_wd;
        end else if (loadEn) begin
            mem[loadIdx] <= loadVal;
        end
    end

    task preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        loadEn  = 1'b1;
        loadIdx = idx;
        loadVal = val;
        @(negedge clk);
        loadEn  = 1'b0;
    endtask

    // This task presents one request for the accept edge, then scrambles
    // the request inputs. It returns the number of edges, counting the
    // accept edge, until resp_valid is seen. The count is capped at 10.
    task doRequest(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                   input logic [31:0] wdata, output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_store  = ~st;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5A5A_5A5A;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task consume;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            loadEn  = 1'b1;
            loadIdx = i[5:0];
            loadVal = 32'd0;
        end
        @(negedge clk);
        loadEn = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b expected 1", req_ready); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b expected 0", resp_valid); end
        checks++;
        if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_resp got rdata %h err %b expected 0/0", resp_rdata, resp_err);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_a !== 16'd0 || mem_wd !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_mem got we %b a %h wd %h expected 0/0/0", mem_we, mem_a, mem_wd);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task test_load_extend;
        int lat;
        logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
        logic [31:0] ad  [6] = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h13, 32'h10};
        logic [31:0] exp [6] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000,
                                 32'h0000_00F0, 32'hFFFF_FF80, 32'h8000_00F0};
        preload(6'd4, 32'h8000_00F0);
        for (int i = 0; i < 6; i++) begin
            doRequest(1'b0, f3[i], ad[i], 32'd0, lat);
            checks++;
            if (lat !== 2) begin errors++; $display("[TB] FAIL load%0d_latency got %0d expected 2", i, lat); end
            checks++;
            if (resp_rdata !== exp[i] || resp_err !== 1'b0) begin
                errors++; $display("[TB] FAIL load%0d_data got %h err %b expected %h err 0", i, resp_rdata, resp_err, exp[i]);
            end
            consume();
        end
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL load_after_consume got valid %b ready %b expected 0/1", resp_valid, req_ready);
        end
    endtask

    task test_store_subword;
        int lat;
        int startWe;
        preload(6'd4, 32'h1122_3344);
        startWe = weCount;
        doRequest(1'b1, 3'b000, 32'h12, 32'h0000_00AB, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL sb_latency got %0d expected 3", lat); end
        checks++;
        if (weCount - startWe !== 1 || lastA !== 16'd4 || lastWd !== 32'h11AB_3344) begin
            errors++; $display("[TB] FAIL sb_write got n %0d a %h wd %h expected 1/4/11ab3344", weCount - startWe, lastA, lastWd);
        end
        checks++;
        if (resp_rdata !== 32'd0 || resp_err !== 1'b0 || mem_a !== 16'd0 || mem_wd !== 32'd0) begin
            errors++; $display("[TB] FAIL sb_resp got rdata %h err %b a %h wd %h expected zeros", resp_rdata, resp_err, mem_a, mem_wd);
        end
        consume();
        doRequest(1'b1, 3'b001, 32'h10, 32'h1234_5678, lat);
        checks++;
        if (lat !== 3 || mem[4] !== 32'h11AB_5678) begin
            errors++; $display("[TB] FAIL sh_write got lat %0d mem %h expected 3/11ab5678", lat, mem[4]);
        end
        consume();
    endtask

    task test_store_word;
        int lat;
        int startWe;
        startWe = weCount;
        doRequest(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL sw_latency got %0d expected 2", lat); end
        checks++;
        if (weCount - startWe !== 1 || lastA !== 16'd2 || lastWd !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL sw_write got n %0d a %h wd %h expected 1/2/deadbeef", weCount - startWe, lastA, lastWd);
        end
        consume();
        doRequest(1'b0, 3'b010, 32'h8, 32'd0, lat);
        checks++;
        if (lat !== 2 || resp_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL lw_readback got lat %0d data %h expected 2/deadbeef", lat, resp_rdata);
        end
        consume();
    endtask

    task test_errors;
        int lat;
        int startWe;
        logic        st [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
        logic [31:0] ad [5] = '{32'h6, 32'h3, 32'h0, 32'h0, 32'h0004_0000};
        for (int i = 0; i < 5; i++) begin
            startWe = weCount;
            doRequest(st[i], f3[i], ad[i], 32'hFFFF_FFFF, lat);
            checks++;
            if (lat !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'd0 || weCount != startWe) begin
                errors++;
                $display("[TB] FAIL err%0d got lat %0d err %b rdata %h writes %0d expected 1/1/0/0",
                         i, lat, resp_err, resp_rdata, weCount - startWe);
            end
            consume();
        end
    endtask

    task test_back_to_back;
        int lat;
        int startWe;
        resp_ready = 1'b0;
        startWe = weCount;
        doRequest(1'b1, 3'b000, 32'h10, 32'h0000_00CD, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL bp_latency got %0d expected 3", lat); end
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h8;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got valid %b ready %b rdata %h err %b expected 1/0/0/0",
                         i, resp_valid, req_ready, resp_rdata, resp_err);
            end
        end
        checks++;
        if (weCount - startWe !== 1 || mem[4] !== 32'h11AB_56CD) begin
            errors++; $display("[TB] FAIL bp_single_write got n %0d mem %h expected 1/11ab56cd", weCount - startWe, mem[4]);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL consume_edge_accept got ready %b valid %b expected 1/0", req_ready, resp_valid);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        doRequest(1'b0, 3'b010, 32'h8, 32'd0, lat);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
                errors++; $display("[TB] FAIL bp_load_hold%0d got valid %b rdata %h expected 1/deadbeef", i, resp_valid, resp_rdata);
            end
        end
        resp_ready = 1'b1;
        consume();
    endtask

    task test_reset_in_wr;
        int startWe;
        int seen;
        preload(6'd5, 32'h5566_7788);
        startWe = weCount;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h14;
        req_wdata  = 32'h0000_0099;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_a !== 16'd5 || mem_wd !== 32'h5566_7799) begin
            errors++; $display("[TB] FAIL rst_wr_state got we %b a %h wd %h expected 1/5/55667799", mem_we, mem_a, mem_wd);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_a !== 16'd0 || mem_wd !== 32'd0 || req_ready !== 1'b1 ||
            resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_abort got we %b a %h wd %h ready %b valid %b expected 0/0/0/1/0",
                               mem_we, mem_a, mem_wd, req_ready, resp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        checks++;
        if (seen !== 0 || weCount != startWe || mem[5] !== 32'h5566_7788) begin
            errors++; $display("[TB] FAIL rst_no_complete got resp %0d writes %0d mem %h expected 0/0/55667788",
                               seen, weCount - startWe, mem[5]);
        end
    endtask

    initial begin
        test_reset();
        test_load_extend();
        test_store_subword();
        test_store_word();
        test_errors();
        test_back_to_back();
        test_reset_in_wr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
